aes_decrypt_core: RTL and testbench
===================================

// Module: aes_decrypt_core
// PURPOSE
//  AES-128 inverse-cipher sequencer, directly downstream of the 32-bit HW/SW transfer block.
//  - Consumes msg_en and the expanded key schedule; produces msg_de.
//  - Handshakes via io_ready (in) / aes_ready (out).
//  - Multi-cycle datapath: one inverse transform per cycle, InvMixColumns one column per cycle.
//  - InvSubBytes and InvMixColumns-column are external combinational units reached through ports.
// PARAMETERS
//  NR  10  number of rounds; key_sched width = 128*(NR+1)
// PORTS
//  clk        in   1       system clock; all logic on posedge
//  reset      in   1       synchronous, active-high
//  io_ready   in   1       upstream has valid msg_en/key; held until aes_ready seen
//  msg_en     in   128     ciphertext, [127:96] = first word
//  key_sched  in   128*(NR+1)  round keys; rk0=[MSB -:128] (cipher key), rkNR=[127:0]
//  ks_valid   in   1       key_sched stable and complete
//  sb_in      out  128     state to external InvSubBytes
//  sb_out     in   128     InvSubBytes(sb_in), combinational
//  mc_in      out  32      column to external InvMixColumns
//  mc_out     in   32      InvMixColumns(mc_in), combinational
//  msg_de     out  128     plaintext result register
//  aes_ready  out  1       result valid / handshake done
// BEHAVIOUR
//  Reset: FSM=IDLE, state reg=0, msg_de=0, aes_ready=0, round=0, col=0.
//  States:
//   IDLE:     if io_ready, capture msg_en into state reg, go WAIT_KS.
//   WAIT_KS:  stay until ks_valid=1, then INIT_ARK.
//   INIT_ARK: state ^= rkNR; round=NR-1; go ISR.
//   ISR:      InvShiftRows (internal wiring); go ISB.
//   ISB:      state = sb_out; go ARK.
//   ARK:      state ^= rk[round].
//             If round==0, load msg_de with the result and go DONE.
//             Otherwise col=0 and go IMC.
//   IMC:      one column per cycle.
//             mc_in = state column col (col0=[127:96] .. col3=[31:0]); column = mc_out.
//             col 3 -> round-=1, go ISR.
//   DONE:     aes_ready=1; stay while io_ready=1; io_ready=0 -> IDLE (aes_ready=0).
//  Latency (ks_valid already high):
//   - aes_ready first high 68 cycles after the IDLE capture edge.
//   - Each middle round takes 7 cycles.
//  Outputs:
//   - sb_in = current state reg; mc_in = 0 outside IMC.
//   - msg_de changes only on ARK(round 0) and is otherwise held.
//  Boundaries:
//   - io_ready held high in DONE: no restart; a new op needs io_ready low for >=1 cycle in IDLE.
//   - ks_valid is only checked in WAIT_KS; key_sched must stay stable until DONE.
//   - reset at any cycle: returns to the reset values on the next edge, no partial msg_de write.
//   - round counter width = $clog2(NR); it never wraps below 0 (DONE path taken at 0).
// CONFIGURATION
//  AES_ABORT_EN undefined:
//   - io_ready deassertion in WAIT_KS..IMC is ignored; the op runs to DONE.
//   - DONE then exits on the next cycle, since io_ready is already low.
//  AES_ABORT_EN defined:
//   - io_ready=0 in any of WAIT_KS..IMC -> IDLE on the next edge.
//   - msg_de keeps its previous value; aes_ready stays 0.
// TESTING
//  1. Ciphertext decrypt:
//     - Stimulus: FIPS-197 C.1 key 000102..0f expanded; msg_en=69c4e0d86a7b0430d8cdb78070b4c55a.
//     - Response: msg_de=00112233445566778899aabbccddeeff; aes_ready rises exactly 68 cycles after capture.
//  2. Late key schedule: ks_valid low for 10 cycles after io_ready -> same result, aes_ready 10 cycles later (78).
//  3. Handshake: hold io_ready high 20 cycles past aes_ready -> aes_ready stays 1, no second run.
//     Then io_ready low -> aes_ready 0 next cycle.
//  4. Reset mid-op: assert reset in cycle 30 of an op -> next cycle msg_de=0, aes_ready=0.
//     Then a fresh op gives the correct plaintext.
//  5. Back-to-back ops (FIPS-197 Appendix B, key 2b7e1516...): expected msg_de=3243f6a8885a308d313198a2e0370734.
//     The second op's msg_de must not disturb the first result until its ARK(round 0).
//  6. AES_ABORT_EN: drop io_ready in cycle 40 -> IDLE next cycle, msg_de=previous value, aes_ready never 1.
//     Without the macro: the same stimulus completes with the correct plaintext.

Source files
------------

// File: rtl/aes_decrypt_core_if.sv
// aes_decrypt_core_if: upstream handshake and key/data bus between the transfer block and the AES decrypt core
interface aes_decrypt_core_if #(parameter int NR = 10);
    logic                   io_ready;
    logic [127:0]           msg_en;
    logic [128*(NR+1)-1:0]  key_sched;
    logic                   ks_valid;
    logic [127:0]           msg_de;
    logic                   aes_ready;

    modport master (output io_ready, msg_en, key_sched, ks_valid, input msg_de, aes_ready);
    modport slave  (input io_ready, msg_en, key_sched, ks_valid, output msg_de, aes_ready);
endinterface

// File: rtl/aes_decrypt_core.sv
// aes_decrypt_core: AES-128 inverse-cipher sequencer, one transform per cycle; AES_ABORT_EN enables abort on io_ready drop
module aes_decrypt_core #(parameter int NR = 10) (
    input  logic               clk,
    input  logic               reset,
    aes_decrypt_core_if.slave  bus,
    output logic [127:0]       sb_in,
    input  logic [127:0]       sb_out,
    output logic [31:0]        mc_in,
    input  logic [31:0]        mc_out
);
    localparam int RW = $clog2(NR);

    typedef enum logic [2:0] {IDLE, WAIT_KS, INIT_ARK, ISR, ISB, ARK, IMC, DONE} st_t;

    st_t           st;
    logic [127:0]  state;
    logic [127:0]  isr;
    logic [127:0]  imc_next;
    logic [127:0]  ark;
    logic [RW-1:0] round;
    logic [1:0]    col;
    logic [127:0]  rks [NR+1];
    logic [31:0]   cols [4];

    // round key r sits (NR-r) slots above the bottom of the schedule
    for (genvar k = 0; k <= NR; k++) begin : g_rk
        assign rks[k] = bus.key_sched[128*(NR-k) +: 128];
    end

    // column views of the state and the state with the current column replaced by mc_out
    for (genvar k = 0; k < 4; k++) begin : g_col
        assign cols[k] = state[127-32*k -: 32];
        assign imc_next[127-32*k -: 32] = (col == 2'(k)) ? mc_out : state[127-32*k -: 32];
    end

    // InvShiftRows is pure wiring: row r rotates right by r columns
    for (genvar c = 0; c < 4; c++) begin : g_isr_c
        for (genvar r = 0; r < 4; r++) begin : g_isr_r
            assign isr[127-8*(4*c+r) -: 8] = state[127-8*(4*((c-r+4)%4)+r) -: 8];
        end
    end

    assign ark   = state ^ rks[round];
    assign sb_in = state;
    assign mc_in = (st == IMC) ? cols[col] : '0;

    // inverse-cipher sequencer with registered result and handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= IDLE;
            state     <= '0;
            bus.msg_de    <= '0;
            bus.aes_ready <= 1'b0;
            round     <= '0;
            col       <= '0;
        end else begin
`ifdef AES_ABORT_EN
            if (st != IDLE && st != DONE && !bus.io_ready)
                st <= IDLE;
            else
`endif
            case (st)
                IDLE: if (bus.io_ready) begin
                    state <= bus.msg_en;
                    st    <= WAIT_KS;
                end
                WAIT_KS: if (bus.ks_valid)
                    st <= INIT_ARK;
                INIT_ARK: begin
                    state <= state ^ rks[NR];
                    round <= RW'(NR-1);
                    st    <= ISR;
                end
                ISR: begin
                    state <= isr;
                    st    <= ISB;
                end
                ISB: begin
                    state <= sb_out;
                    st    <= ARK;
                end
                ARK: begin
                    state <= ark;
                    if (round == '0) begin
                        bus.msg_de    <= ark;
                        bus.aes_ready <= 1'b1;
                        st            <= DONE;
                    end else begin
                        col <= '0;
                        st  <= IMC;
                    end
                end
                IMC: begin
                    state <= imc_next;
                    col   <= col + 2'd1;
                    if (col == 2'd3) begin
                        round <= round - 1'b1;
                        st    <= ISR;
                    end
                end
                DONE: if (!bus.io_ready) begin
                    bus.aes_ready <= 1'b0;
                    st            <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_decrypt_core.sv
// tb_aes_decrypt_core: vector table plus random encrypt-model round trips and handshake/reset/abort sequences
module tb_aes_decrypt_core;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        int           kd;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] sb_in, sb_out;
    logic [31:0]  mc_in, mc_out;
    int           tests = 0;
    int           fails = 0;
    vec_t         vt [10];

    aes_decrypt_core_if #(.NR(10)) bus ();

    aes_decrypt_core #(.NR(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .sb_in  (sb_in),
        .sb_out (sb_out),
        .mc_in  (mc_in),
        .mc_out (mc_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    // multiplicative inverse as a^254 (maps 0 to 0)
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r, p;
        logic [7:0] e;
        r = 8'h01;
        p = a;
        e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gm(r, p);
            p = gm(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] isbox(input logic [7:0] y);
        return ginv(rl(y, 1) ^ rl(y, 3) ^ rl(y, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] sub_st(input logic [127:0] s, input bit inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = inv ? isbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
        return r;
    endfunction

    function automatic logic [127:0] shift_st(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++)
                r[127-8*(4*c+k) -: 8] = s[127-8*(4*((c+k)%4)+k) -: 8];
        return r;
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] w, input bit inv);
        logic [7:0]  m [4];
        logic [7:0]  a [4];
        logic [31:0] o;
        m[0] = inv ? 8'h0e : 8'h02;
        m[1] = inv ? 8'h0b : 8'h03;
        m[2] = inv ? 8'h0d : 8'h01;
        m[3] = inv ? 8'h09 : 8'h01;
        for (int j = 0; j < 4; j++) a[j] = w[31-8*j -: 8];
        o = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                o[31-8*i -: 8] ^= gm(a[j], m[(j-i+4)%4]);
        return o;
    endfunction

    function automatic logic [1407:0] expand(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] ks;
        rc = 8'h01;
        ks = '0;
        for (int i = 0; i < 44; i++) begin
            if (i < 4) w[i] = key[127-32*i -: 32];
            else begin
                t = w[i-1];
                if (i % 4 == 0) begin
                    t = {t[23:0], t[31:24]};
                    t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                    rc = xt(rc);
                end
                w[i] = w[i-4] ^ t;
            end
            ks = {ks[1375:0], w[i]};
        end
        return ks;
    endfunction

    // forward cipher; the DUT must invert it
    function automatic logic [127:0] enc(input logic [127:0] pt, input logic [1407:0] ks);
        logic [127:0] s;
        s = pt ^ ks[1407 -: 128];
        for (int r = 1; r <= 10; r++) begin
            s = shift_st(sub_st(s, 1'b0));
            if (r < 10)
                for (int c = 0; c < 4; c++) s[127-32*c -: 32] = mix(s[127-32*c -: 32], 1'b0);
            s ^= ks[1407-128*r -: 128];
        end
        return s;
    endfunction

    assign sb_out = sub_st(sb_in, 1'b1);
    assign mc_out = mix(mc_in, 1'b1);

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // start an op; n counts edges after the capture edge; lat = -1 if aes_ready never rises
    task automatic run_op(input logic [127:0] ct, input logic [1407:0] ks, input int kd,
                          input int drop_at, input int probe_at,
                          output logic [127:0] res, output int lat, output logic [127:0] pv);
        @(negedge clk);
        bus.msg_en    = ct;
        bus.key_sched = ks;
        bus.ks_valid  = (kd == 0);
        bus.io_ready  = 1'b1;
        lat = -1;
        res = '0;
        pv  = '0;
        for (int n = 0; n < 150; n++) begin
            @(negedge clk);
            if (n == kd) bus.ks_valid = 1'b1;
            if (n == drop_at) bus.io_ready = 1'b0;
            if (n == probe_at) pv = bus.msg_de;
            if (bus.aes_ready) begin
                lat = n;
                res = bus.msg_de;
                break;
            end
        end
    endtask

    task automatic finish_op(output logic rdy);
        bus.io_ready = 1'b0;
        @(negedge clk);
        rdy = bus.aes_ready;
    endtask

    initial begin
        logic [127:0] res, pv, k;
        int           lat, bad;
        logic         rdy;
        reset         = 1'b1;
        bus.io_ready  = 1'b0;
        bus.ks_valid  = 1'b0;
        bus.msg_en    = '0;
        bus.key_sched = '0;
        repeat (3) @(negedge clk);
        chk("reset msg_de", bus.msg_de, '0);
        chk("reset aes_ready", {127'b0, bus.aes_ready}, '0);
        chk("reset sb_in", sb_in, '0);
        chk("reset mc_in", {96'b0, mc_in}, '0);
        reset = 1'b0;

        vt[0] = '{K1, C1, P1, 0};
        vt[1] = '{K1, C1, P1, 10};
        vt[2] = '{K2, C2, P2, 0};
        for (int i = 3; i < 10; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            vt[i].key = k;
            vt[i].pt  = {$urandom, $urandom, $urandom, $urandom};
            vt[i].ct  = enc(vt[i].pt, expand(k));
            vt[i].kd  = int'($urandom_range(0, 3));
        end

        for (int i = 0; i < 10; i++) begin
            run_op(vt[i].ct, expand(vt[i].key), vt[i].kd, -1, -1, res, lat, pv);
            chk($sformatf("vec%0d plaintext", i), res, vt[i].pt);
            chk_i($sformatf("vec%0d latency", i), lat, 68 + vt[i].kd);
            finish_op(rdy);
            chk($sformatf("vec%0d ready drop", i), {127'b0, rdy}, '0);
        end

        run_op(C1, expand(K1), 0, -1, -1, res, lat, pv);
        chk_i("hold latency", lat, 68);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.aes_ready !== 1'b1 || bus.msg_de !== P1 || mc_in !== '0) bad++;
        end
        chk_i("hold stable cycles bad", bad, 0);
        finish_op(rdy);
        chk("hold release ready", {127'b0, rdy}, '0);

        @(negedge clk);
        bus.msg_en    = C2;
        bus.key_sched = expand(K2);
        bus.ks_valid  = 1'b1;
        bus.io_ready  = 1'b1;
        repeat (30) @(negedge clk);
        reset        = 1'b1;
        bus.io_ready = 1'b0;
        @(negedge clk);
        chk("midreset msg_de", bus.msg_de, '0);
        chk("midreset aes_ready", {127'b0, bus.aes_ready}, '0);
        reset = 1'b0;
        run_op(C1, expand(K1), 0, -1, -1, res, lat, pv);
        chk("post reset plaintext", res, P1);
        chk_i("post reset latency", lat, 68);
        finish_op(rdy);

        run_op(C2, expand(K2), 0, -1, 67, res, lat, pv);
        chk("b2b held previous", pv, P1);
        chk("b2b plaintext", res, P2);
        chk_i("b2b latency", lat, 68);
        finish_op(rdy);

        run_op(C1, expand(K1), 0, 40, -1, res, lat, pv);
`ifdef AES_ABORT_EN
        chk_i("abort latency", lat, -1);
        chk("abort msg_de kept", bus.msg_de, P2);
        run_op(C1, expand(K1), 0, -1, -1, res, lat, pv);
        chk("after abort plaintext", res, P1);
        chk_i("after abort latency", lat, 68);
`else
        chk("no-abort plaintext", res, P1);
        chk_i("no-abort latency", lat, 68);
        @(negedge clk);
        chk("no-abort done exit", {127'b0, bus.aes_ready}, '0);
`endif
        finish_op(rdy);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
